// File: rtl/filter_frame_ctrl.sv
// Frame sequencer for kernel_filter: buffers two lines, issues interior 3x3 windows, counts results to done.
// Window valid 1 cycle after the accepting pixel; result path 1 cycle; pixels stall freely, results are never stalled. Option: FILTER_FRAME_RES_CNT_EN adds o_res_cnt.
module filter_frame_ctrl #(
    parameter int IMG_W       = 8,
    parameter int IMG_H       = 8,
    parameter int DATA_SIZE   = 8,
    parameter int KERNEL_SIZE = 3,
    localparam int NWIN       = (IMG_W - 2) * (IMG_H - 2),
    localparam int PW         = $clog2(NWIN + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_nrst,
    input  logic                   i_start,
    input  logic [1:0]             i_cfg_select,
    input  logic                   i_pix_valid,
    input  logic [DATA_SIZE-1:0]   i_pix_data,
    output logic                   o_pix_ready,
    output logic                   o_flt_valid,
    output logic [9*DATA_SIZE-1:0] o_flt_window,
    output logic [1:0]             o_flt_cfg,
    input  logic                   i_flt_ready,
    input  logic [DATA_SIZE-1:0]   i_flt_data,
    output logic                   o_res_valid,
    output logic [DATA_SIZE-1:0]   o_res_data,
    output logic                   o_busy,
`ifdef FILTER_FRAME_RES_CNT_EN
    output logic [PW-1:0]          o_res_cnt,
`endif
    output logic                   o_done
);

    localparam int NTAP = KERNEL_SIZE * KERNEL_SIZE;
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                                 state_q, state_d;
    logic [1:0]                             cfg_q, cfg_d;
    logic [CW-1:0]                          col_q, col_d;
    logic [RW-1:0]                          row_q, row_d;
    logic [IMG_W-1:0][DATA_SIZE-1:0]        lb0_q, lb0_d;
    logic [IMG_W-1:0][DATA_SIZE-1:0]        lb1_q, lb1_d;
    logic [NTAP-1:0][DATA_SIZE-1:0]         win_q, win_d;
    logic [NTAP-1:0][DATA_SIZE-1:0]         flt_win_q, flt_win_d;
    logic                                   flt_valid_q, flt_valid_d;
    logic [PW-1:0]                          pend_q, pend_d;
    logic                                   res_valid_q, res_valid_d;
    logic [DATA_SIZE-1:0]                   res_data_q, res_data_d;
    logic [PW-1:0]                          res_cnt_q, res_cnt_d;
    logic                                   pix_ready;
    logic                                   accept;

    assign pix_ready = (state_q == S_FILL) || (state_q == S_RUN);
    assign accept    = pix_ready && i_pix_valid;

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        col_d       = col_q;
        row_d       = row_q;
        lb0_d       = lb0_q;
        lb1_d       = lb1_q;
        win_d       = win_q;
        flt_win_d   = flt_win_q;
        flt_valid_d = 1'b0;
        pend_d      = pend_q;
        res_valid_d = i_flt_ready;
        res_data_d  = i_flt_data;
        res_cnt_d   = res_cnt_q;

        if (res_valid_q) begin
            res_cnt_d = res_cnt_q + PW'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d   = S_FILL;
                    cfg_d     = i_cfg_select;
                    col_d     = '0;
                    row_d     = '0;
                    res_cnt_d = '0;
                end
            end
            S_FILL: begin
                if (accept && row_q == RW'(1) && col_q == COL_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (accept && row_q == ROW_LAST && col_q == COL_LAST) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // A window issued this cycle is still owed a result even though pend_q has not counted it yet.
                if (pend_q == '0 && !i_flt_ready && !flt_valid_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            lb0_d[col_q] = lb1_q[col_q];
            lb1_d[col_q] = i_pix_data;
            for (int r = 0; r < 3; r++) begin
                win_d[r*3+0] = win_q[r*3+1];
                win_d[r*3+1] = win_q[r*3+2];
            end
            win_d[2] = lb0_q[col_q];
            win_d[5] = lb1_q[col_q];
            win_d[8] = i_pix_data;
            if (row_q >= RW'(2) && col_q >= CW'(2)) begin
                flt_valid_d = 1'b1;
                flt_win_d   = win_d;
            end
        end

        // A stray result with nothing outstanding is forwarded but not counted.
        unique case ({flt_valid_q, i_flt_ready})
            2'b10:   pend_d = pend_q + PW'(1);
            2'b01:   pend_d = (pend_q != '0) ? pend_q - PW'(1) : pend_q;
            default: pend_d = pend_q;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q     <= S_IDLE;
            cfg_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            lb0_q       <= '0;
            lb1_q       <= '0;
            win_q       <= '0;
            flt_win_q   <= '0;
            flt_valid_q <= 1'b0;
            pend_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            col_q       <= col_d;
            row_q       <= row_d;
            lb0_q       <= lb0_d;
            lb1_q       <= lb1_d;
            win_q       <= win_d;
            flt_win_q   <= flt_win_d;
            flt_valid_q <= flt_valid_d;
            pend_q      <= pend_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_cnt_q   <= res_cnt_d;
        end
    end

    assign o_pix_ready  = pix_ready;
    assign o_flt_valid  = flt_valid_q;
    assign o_flt_window = flt_win_q;
    assign o_flt_cfg    = cfg_q;
    assign o_res_valid  = res_valid_q;
    assign o_res_data   = res_data_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_done       = (state_q == S_DONE);

`ifdef FILTER_FRAME_RES_CNT_EN
    assign o_res_cnt = res_cnt_q;
`else
    logic unused_res_cnt;
    assign unused_res_cnt = ^res_cnt_q;
`endif

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// Bench for filter_frame_ctrl: a 4x4 and an 8x8 instance, a 2-cycle filter model, window/result scoreboards.
module tb_filter_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       nrst;
    logic       start;
    logic [1:0] cfg_sel;
    logic       pix_valid;
    logic [7:0] pix_data;
    int         sel;
    logic       stray;
    logic [7:0] stray_data;

    logic        pv [2];
    logic        st [2];
    logic        pr [2];
    logic        fv [2];
    logic [71:0] fw [2];
    logic [1:0]  fcfg [2];
    logic        fr [2];
    logic [7:0]  fd [2];
    logic        rv [2];
    logic [7:0]  rd [2];
    logic        busy [2];
    logic        done [2];
    logic [2:0]  rcnt4;
    logic [5:0]  rcnt8;

    logic       s1v [2];
    logic       s2v [2];
    logic [7:0] s1d [2];
    logic [7:0] s2d [2];

    for (genvar g = 0; g < 2; g++) begin : g_drv
        assign pv[g] = pix_valid && (sel == g);
        assign st[g] = start && (sel == g);
        assign fr[g] = s2v[g] || (stray && sel == g);
        assign fd[g] = (stray && sel == g) ? stray_data : s2d[g];
    end

    filter_frame_ctrl #(.IMG_W(4), .IMG_H(4), .DATA_SIZE(8), .KERNEL_SIZE(3)) u4 (
        .i_clk(clk), .i_nrst(nrst), .i_start(st[0]), .i_cfg_select(cfg_sel),
        .i_pix_valid(pv[0]), .i_pix_data(pix_data), .o_pix_ready(pr[0]),
        .o_flt_valid(fv[0]), .o_flt_window(fw[0]), .o_flt_cfg(fcfg[0]),
        .i_flt_ready(fr[0]), .i_flt_data(fd[0]), .o_res_valid(rv[0]), .o_res_data(rd[0]),
        .o_busy(busy[0]),
`ifdef FILTER_FRAME_RES_CNT_EN
        .o_res_cnt(rcnt4),
`endif
        .o_done(done[0]));

    filter_frame_ctrl #(.IMG_W(8), .IMG_H(8), .DATA_SIZE(8), .KERNEL_SIZE(3)) u8 (
        .i_clk(clk), .i_nrst(nrst), .i_start(st[1]), .i_cfg_select(cfg_sel),
        .i_pix_valid(pv[1]), .i_pix_data(pix_data), .o_pix_ready(pr[1]),
        .o_flt_valid(fv[1]), .o_flt_window(fw[1]), .o_flt_cfg(fcfg[1]),
        .i_flt_ready(fr[1]), .i_flt_data(fd[1]), .o_res_valid(rv[1]), .o_res_data(rd[1]),
        .o_busy(busy[1]),
`ifdef FILTER_FRAME_RES_CNT_EN
        .o_res_cnt(rcnt8),
`endif
        .o_done(done[1]));

    function automatic logic [7:0] fsum(input logic [71:0] w, input logic [1:0] c);
        logic [7:0] s;
        s = 8'd0;
        for (int j = 0; j < 9; j++) s = s + w[j*8 +: 8];
        return s ^ {6'd0, c};
    endfunction

    // Filter model: result = byte sum of the window xor config, two cycles after the window.
    initial begin
        for (int k = 0; k < 2; k++) begin
            s1v[k] = 1'b0; s2v[k] = 1'b0; s1d[k] = 8'd0; s2d[k] = 8'd0;
        end
    end
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            s1v[k] <= fv[k];
            s1d[k] <= fsum(fw[k], fcfg[k]);
            s2v[k] <= s1v[k];
            s2d[k] <= s1d[k];
        end
    end

    int ncmp = 0;
    int nerr = 0;
    logic [71:0] winq [$];
    logic [7:0]  resq [$];
    logic [1:0]  exp_cfg;
    int nwin = 0;
    int nres = 0;
    int ndone = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (nrst) begin
            if (fv[sel]) begin
                if (winq.size() == 0) begin
                    check("flt_valid_unexpected", 72'd1, 72'd0);
                end else begin
                    check("window", fw[sel], winq.pop_front());
                    check("flt_cfg", {70'd0, fcfg[sel]}, {70'd0, exp_cfg});
                end
                nwin++;
            end
            if (rv[sel]) begin
                if (resq.size() == 0) check("res_valid_unexpected", 72'd1, 72'd0);
                else check("res_data", {64'd0, rd[sel]}, {64'd0, resq.pop_front()});
                nres++;
            end
            if (done[sel]) ndone++;
        end
    end

    typedef struct {
        int         dut;
        logic [1:0] cfg;
        int         stall_every;
        int         stall_len;
        int         mid_idx;
        int         base;
        bit         stray_before;
        int         exp_windows;
    } frame_vec_t;

    task automatic run_frame(input frame_vec_t v);
        int w, h, d0, w0, r0;
        bit got;
        logic [7:0]  px [64];
        logic [71:0] win;
        sel = v.dut;
        w = (v.dut == 1) ? 8 : 4;
        h = w;
        if (v.stray_before) begin
            @(posedge clk); #1;
            stray = 1'b1; stray_data = 8'h5A;
            resq.push_back(8'h5A);
            @(posedge clk); #1;
            stray = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            check("stray_forwarded", 72'(resq.size()), 72'd0);
        end
        d0 = ndone; w0 = nwin; r0 = nres;
        exp_cfg = v.cfg;
        @(posedge clk); #1;
        cfg_sel = v.cfg; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {71'd0, busy[sel]}, 72'd1);
`ifdef FILTER_FRAME_RES_CNT_EN
        if (v.dut == 1) check("res_cnt_cleared", {66'd0, rcnt8}, 72'd0);
`endif
        for (int i = 0; i < w * h; i++) px[i] = 8'(v.base + i);
        for (int i = 0; i < w * h; i++) begin
            int r, c;
            r = i / w; c = i % w;
            pix_valid = 1'b1;
            pix_data = px[i];
            if (i == v.mid_idx) begin
                start = 1'b1; cfg_sel = 2'd1;
            end
            check("pix_ready", {71'd0, pr[sel]}, 72'd1);
            if (r >= 2 && c >= 2) begin
                for (int rr = 0; rr < 3; rr++)
                    for (int cc = 0; cc < 3; cc++)
                        win[(rr*3+cc)*8 +: 8] = px[(r-2+rr)*w + (c-2+cc)];
                winq.push_back(win);
                resq.push_back(fsum(win, v.cfg));
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (v.stall_every > 0 && (i % v.stall_every) == v.stall_every - 1 && i != w*h-1) begin
                pix_valid = 1'b0;
                repeat (v.stall_len) begin
                    check("pix_ready_stall", {71'd0, pr[sel]}, 72'd1);
                    @(posedge clk); #1;
                end
            end
        end
        pix_valid = 1'b0;
        check("pix_ready_drain", {71'd0, pr[sel]}, 72'd0);
        got = 1'b0;
        for (int cyc = 0; cyc < 200 && !got; cyc++) begin
            @(negedge clk);
            if (done[sel]) got = 1'b1;
        end
        if (!got) begin
            check("done_timeout", 72'd0, 72'd1);
        end else begin
            check("windows", 72'(nwin - w0), 72'(v.exp_windows));
            check("results", 72'(nres - r0), 72'(v.exp_windows));
            check("queues_left", 72'(winq.size() + resq.size()), 72'd0);
            check("busy_at_done", {71'd0, busy[sel]}, 72'd1);
`ifdef FILTER_FRAME_RES_CNT_EN
            if (v.dut == 1) check("res_cnt_at_done", {66'd0, rcnt8}, 72'(v.exp_windows));
`endif
            @(negedge clk);
            check("busy_after_done", {71'd0, busy[sel]}, 72'd0);
            check("done_one_cycle", {71'd0, done[sel]}, 72'd0);
        end
        repeat (5) @(negedge clk);
        check("done_count", 72'(ndone - d0), 72'd1);
`ifdef FILTER_FRAME_RES_CNT_EN
        if (v.dut == 1) check("res_cnt_hold", {66'd0, rcnt8}, 72'(v.exp_windows));
`endif
        winq.delete(); resq.delete();
    endtask

    task automatic check_zero(input int k, input string tag);
        check({tag, "_pix_ready"}, {71'd0, pr[k]}, 72'd0);
        check({tag, "_flt_valid"}, {71'd0, fv[k]}, 72'd0);
        check({tag, "_flt_window"}, fw[k], 72'd0);
        check({tag, "_flt_cfg"}, {70'd0, fcfg[k]}, 72'd0);
        check({tag, "_res_valid"}, {71'd0, rv[k]}, 72'd0);
        check({tag, "_res_data"}, {64'd0, rd[k]}, 72'd0);
        check({tag, "_busy"}, {71'd0, busy[k]}, 72'd0);
        check({tag, "_done"}, {71'd0, done[k]}, 72'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_vec_t vecs [5];
        int d0;
        vecs[0] = '{dut:0, cfg:2'd0, stall_every:0, stall_len:0, mid_idx:-1, base:1,   stray_before:0, exp_windows:4};
        vecs[1] = '{dut:0, cfg:2'd0, stall_every:2, stall_len:3, mid_idx:-1, base:1,   stray_before:0, exp_windows:4};
        vecs[2] = '{dut:0, cfg:2'd3, stall_every:0, stall_len:0, mid_idx:7,  base:1,   stray_before:0, exp_windows:4};
        vecs[3] = '{dut:1, cfg:2'd2, stall_every:3, stall_len:1, mid_idx:20, base:37,  stray_before:0, exp_windows:36};
        vecs[4] = '{dut:0, cfg:2'd1, stall_every:0, stall_len:0, mid_idx:-1, base:200, stray_before:1, exp_windows:4};

        nrst = 1'b0; start = 1'b0; cfg_sel = 2'd0; pix_valid = 1'b0; pix_data = 8'd0;
        sel = 0; stray = 1'b0; stray_data = 8'd0; exp_cfg = 2'd0;
        #12;
        check_zero(0, "reset4");
        check_zero(1, "reset8");
        @(posedge clk); #1;
        nrst = 1'b1;

        for (int t = 0; t < 5; t++) run_frame(vecs[t]);

        // Abort an 8x8 frame after 9 pixels, then run a full frame on the same instance.
        sel = 1;
        d0 = ndone;
        @(posedge clk); #1;
        cfg_sel = 2'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
`ifdef FILTER_FRAME_RES_CNT_EN
        check("res_cnt_restart", {66'd0, rcnt8}, 72'd0);
`endif
        for (int i = 0; i < 9; i++) begin
            pix_valid = 1'b1; pix_data = 8'(90 + i);
            @(posedge clk); #1;
        end
        pix_valid = 1'b0;
        nrst = 1'b0;
        #1;
        check_zero(1, "abort");
        @(posedge clk); #1;
        nrst = 1'b1;
        repeat (20) @(negedge clk);
        check("no_done_after_abort", 72'(ndone - d0), 72'd0);
        check("idle_after_abort", {71'd0, busy[1]}, 72'd0);
        run_frame('{dut:1, cfg:2'd1, stall_every:0, stall_len:0, mid_idx:-1, base:3, stray_before:0, exp_windows:36});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
